// File: rtl/imem_loader_if.sv
// Loader-facing bus: serial byte stream in, instruction-memory write port and CPU control out.
// The loader takes the slave modport; the byte source / system side takes the master modport.
interface imem_loader_if #(
    parameter int ADDR_W = 10
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              reload;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;
    logic              cpu_reset;
    logic              load_done;
    logic              load_error;
    logic [ADDR_W:0]   words_loaded;

    modport master (
        output rx_data, rx_valid, reload,
        input  rx_ready, im_we, im_addr, im_wdata,
        input  cpu_reset, load_done, load_error, words_loaded
    );

    modport slave (
        input  rx_data, rx_valid, reload,
        output rx_ready, im_we, im_addr, im_wdata,
        output cpu_reset, load_done, load_error, words_loaded
    );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: length-prefixed byte stream -> big-endian words in imem; im_we one cycle after each 4th byte.
// rx_ready is a registered state decode, so a stalled rx_valid simply parks the FSM.
module imem_loader #(
    parameter int ADDR_W    = 10,
    parameter int MAX_WORDS = 1024
) (
    input  logic         CLK,
    input  logic         Reset,
    imem_loader_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    localparam int          CNT_W = ADDR_W + 1;
    localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

    state_t            state_q,      state_d;
    logic [7:0]        len_hi_q,     len_hi_d;
    logic [CNT_W-1:0]  len_q,        len_d;
    logic [1:0]        byte_cnt_q,   byte_cnt_d;
    logic [CNT_W-1:0]  word_cnt_q,   word_cnt_d;
    logic [7:0]        csum_q,       csum_d;
    logic [23:0]       asm_q,        asm_d;
    logic              rx_ready_q,   rx_ready_d;
    logic              im_we_q,      im_we_d;
    logic [ADDR_W-1:0] im_addr_q,    im_addr_d;
    logic [31:0]       im_wdata_q,   im_wdata_d;
    logic              cpu_reset_q,  cpu_reset_d;
    logic              load_done_q,  load_done_d;
    logic              load_error_q, load_error_d;

    logic        xfer;
    logic [15:0] len_in;
    logic        last_word;

    assign xfer      = bus.rx_valid && rx_ready_q;
    assign len_in    = {len_hi_q, bus.rx_data};
    assign last_word = (word_cnt_q + CNT_W'(1)) == len_q;

    always_comb begin
        state_d    = state_q;
        len_hi_d   = len_hi_q;
        len_d      = len_q;
        byte_cnt_d = byte_cnt_q;
        word_cnt_d = word_cnt_q;
        csum_d     = csum_q;
        asm_d      = asm_q;
        im_we_d    = 1'b0;
        im_addr_d  = im_addr_q;
        im_wdata_d = im_wdata_q;

        case (state_q)
            S_IDLE: state_d = S_LEN_HI;

            S_LEN_HI: begin
                if (xfer) begin
                    len_hi_d = bus.rx_data;
                    state_d  = S_LEN_LO;
                end
            end

            S_LEN_LO: begin
                if (xfer) begin
                    if ({1'b0, len_in} > MAX_N) begin
                        state_d = S_ERROR;
                    end else if (len_in == 16'd0) begin
                        state_d = S_CHECK;
                    end else begin
                        // Fits in CNT_W bits because it was bounded by MAX_WORDS above.
                        len_d   = len_in[CNT_W-1:0];
                        state_d = S_DATA;
                    end
                end
            end

            S_DATA: begin
                if (xfer) begin
                    csum_d     = csum_q ^ bus.rx_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    asm_d      = {asm_q[15:0], bus.rx_data};
                    if (byte_cnt_q == 2'd3) begin
                        im_we_d    = 1'b1;
                        im_addr_d  = word_cnt_q[ADDR_W-1:0];
                        im_wdata_d = {asm_q, bus.rx_data};
                        word_cnt_d = word_cnt_q + CNT_W'(1);
                        if (last_word) begin
                            state_d = S_CHECK;
                        end
                    end
                end
            end

            S_CHECK: begin
                if (xfer) begin
                    state_d = (bus.rx_data == csum_q) ? S_DONE : S_ERROR;
                end
            end

            S_DONE, S_ERROR: begin
                // Memory image and last im_addr/im_wdata are deliberately kept across a reload.
                if (bus.reload) begin
                    state_d    = S_LEN_HI;
                    len_hi_d   = '0;
                    len_d      = '0;
                    byte_cnt_d = '0;
                    word_cnt_d = '0;
                    csum_d     = '0;
                    asm_d      = '0;
                end
            end

            default: state_d = S_IDLE;
        endcase

        rx_ready_d   = (state_d == S_LEN_HI) || (state_d == S_LEN_LO) ||
                       (state_d == S_DATA)   || (state_d == S_CHECK);
        cpu_reset_d  = (state_d != S_DONE);
        load_done_d  = (state_d == S_DONE);
        load_error_d = (state_d == S_ERROR);
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            len_hi_q     <= '0;
            len_q        <= '0;
            byte_cnt_q   <= '0;
            word_cnt_q   <= '0;
            csum_q       <= '0;
            asm_q        <= '0;
            rx_ready_q   <= 1'b0;
            im_we_q      <= 1'b0;
            im_addr_q    <= '0;
            im_wdata_q   <= '0;
            cpu_reset_q  <= 1'b1;
            load_done_q  <= 1'b0;
            load_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_hi_q     <= len_hi_d;
            len_q        <= len_d;
            byte_cnt_q   <= byte_cnt_d;
            word_cnt_q   <= word_cnt_d;
            csum_q       <= csum_d;
            asm_q        <= asm_d;
            rx_ready_q   <= rx_ready_d;
            im_we_q      <= im_we_d;
            im_addr_q    <= im_addr_d;
            im_wdata_q   <= im_wdata_d;
            cpu_reset_q  <= cpu_reset_d;
            load_done_q  <= load_done_d;
            load_error_q <= load_error_d;
        end
    end

    assign bus.rx_ready     = rx_ready_q;
    assign bus.im_we        = im_we_q;
    assign bus.im_addr      = im_addr_q;
    assign bus.im_wdata     = im_wdata_q;
    assign bus.cpu_reset    = cpu_reset_q;
    assign bus.load_done    = load_done_q;
    assign bus.load_error   = load_error_q;
    assign bus.words_loaded = word_cnt_q;
endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: stream-level reference model checked every cycle, plus directed literal checks.
module tb_imem_loader;
    localparam int ADDR_W    = 10;
    localparam int MAX_WORDS = 1024;

    logic CLK   = 1'b0;
    logic Reset = 1'b1;

    imem_loader_if #(.ADDR_W(ADDR_W)) ifc ();

    imem_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (ifc.slave)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model: the accepted byte stream of the current load ----------------
    logic [7:0]        sbuf [0:4200];
    int                k;
    bit                idle;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [31:0]       m_wdata;
    logic [7:0]        xacc;

    function automatic int m_len();
        if (k < 2) return 0;
        return int'({sbuf[0], sbuf[1]});
    endfunction

    // 0 = still loading, 1 = loaded and checksum good, 2 = rejected
    function automatic int m_status();
        int n;
        if (k < 2) return 0;
        n = m_len();
        if (n > MAX_WORDS) return 2;
        if (k < 4 * n + 3) return 0;
        return (xacc == sbuf[4 * n + 2]) ? 1 : 2;
    endfunction

    function automatic bit m_ready();
        return !idle && (m_status() == 0);
    endfunction

    function automatic int m_words();
        int n;
        if (k < 2) return 0;
        n = m_len();
        if (n > MAX_WORDS) return 0;
        return ((k - 2) / 4 < n) ? (k - 2) / 4 : n;
    endfunction

    always @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            k       <= 0;
            idle    <= 1'b1;
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            xacc    <= '0;
        end else begin
            m_we <= 1'b0;
            if (idle) begin
                idle <= 1'b0;
            end else if (m_status() != 0 && ifc.reload) begin
                k    <= 0;
                xacc <= '0;
            end else if (m_ready() && ifc.rx_valid) begin
                sbuf[k] <= ifc.rx_data;
                k       <= k + 1;
                if (k >= 2 && k < 4 * m_len() + 2) begin
                    xacc <= xacc ^ ifc.rx_data;
                    if ((k - 2) % 4 == 3) begin
                        m_we    <= 1'b1;
                        m_addr  <= ADDR_W'((k - 2) / 4);
                        m_wdata <= {sbuf[k-3], sbuf[k-2], sbuf[k-1], ifc.rx_data};
                    end
                end
            end
        end
    end

    // ---------------- per-cycle comparison and write capture ----------------
    logic [31:0] dut_mem [0:MAX_WORDS-1];
    int          we_cnt = 0;

    always @(negedge CLK) begin
        check("rx_ready",     64'(ifc.rx_ready),     64'(m_ready()));
        check("im_we",        64'(ifc.im_we),        64'(m_we));
        check("im_addr",      64'(ifc.im_addr),      64'(m_addr));
        check("im_wdata",     64'(ifc.im_wdata),     64'(m_wdata));
        check("cpu_reset",    64'(ifc.cpu_reset),    64'(m_status() != 1));
        check("load_done",    64'(ifc.load_done),    64'(m_status() == 1));
        check("load_error",   64'(ifc.load_error),   64'(m_status() == 2));
        check("words_loaded", 64'(ifc.words_loaded), 64'(m_words()));
        if (ifc.im_we === 1'b1) begin
            dut_mem[ifc.im_addr] <= ifc.im_wdata;
            we_cnt               <= we_cnt + 1;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // gap_mode: 0 back-to-back, 1 valid toggles every cycle, 2 random idle gaps
    task automatic send(input logic [7:0] b, input int gap_mode, input bit noise);
        bit ok;
        ok           = 1'b0;
        ifc.rx_data  = b;
        ifc.rx_valid = 1'b1;
        ifc.reload   = noise && ($urandom_range(0, 5) == 0);
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (ifc.rx_ready) begin
                @(posedge CLK);
                #1;
                ok = 1'b1;
                break;
            end
        end
        ifc.rx_valid = 1'b0;
        ifc.reload   = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=not_accepted required=accepted byte=%0h", b);
        end
        if (gap_mode == 1) tick();
        if (gap_mode == 2) repeat ($urandom_range(0, 2)) tick();
    endtask

    task automatic send_stream(input logic [7:0] s[$], input int gap_mode, input bit noise);
        foreach (s[i]) send(s[i], gap_mode, noise);
    endtask

    task automatic make_stream(input int n, input bit bad, output logic [7:0] s[$]);
        logic [7:0] x;
        logic [7:0] b;
        s = {};
        x = 8'h00;
        s.push_back(8'(n >> 8));
        s.push_back(8'(n));
        for (int i = 0; i < 4 * n; i++) begin
            b = 8'($urandom);
            x = x ^ b;
            s.push_back(b);
        end
        if (bad) x = x ^ 8'($urandom_range(1, 255));
        s.push_back(x);
    endtask

    task automatic pulse_reload();
        ifc.reload = 1'b1;
        tick();
        ifc.reload = 1'b0;
    endtask

    task automatic do_reset();
        ifc.rx_valid = 1'b0;
        Reset        = 1'b1;
        repeat (2) tick();
        Reset = 1'b0;
    endtask

    initial begin
        logic [7:0] s1_good[$];
        logic [7:0] s1_bad[$];
        logic [7:0] rs[$];
        int         we0;
        int         n;
        bit         bad;

        s1_good = '{8'h00, 8'h02, 8'h3C, 8'h08, 8'h00, 8'h10, 8'h21, 8'h09, 8'h00, 8'h05, 8'h09};
        s1_bad  = '{8'h00, 8'h02, 8'h3C, 8'h08, 8'h00, 8'h10, 8'h21, 8'h09, 8'h00, 8'h05, 8'h1C};

        ifc.rx_data  = 8'h00;
        ifc.rx_valid = 1'b0;
        ifc.reload   = 1'b0;
        repeat (3) tick();
        check("rst_rx_ready",  64'(ifc.rx_ready),     64'd0);
        check("rst_cpu_reset", 64'(ifc.cpu_reset),    64'd1);
        check("rst_im_addr",   64'(ifc.im_addr),      64'd0);
        check("rst_words",     64'(ifc.words_loaded), 64'd0);
        Reset = 1'b0;

        // good two-word program, back-to-back bytes
        send_stream(s1_good, 0, 1'b0);
        tick();
        check("t1_done",      64'(ifc.load_done),    64'd1);
        check("t1_cpu_reset", 64'(ifc.cpu_reset),    64'd0);
        check("t1_words",     64'(ifc.words_loaded), 64'd2);
        check("t1_mem0",      64'(dut_mem[0]),       64'h3C080010);
        check("t1_mem1",      64'(dut_mem[1]),       64'h21090005);
        check("t1_we_cnt",    64'(we_cnt),           64'd2);

        // same program, wrong checksum
        pulse_reload();
        we0 = we_cnt;
        send_stream(s1_bad, 0, 1'b0);
        tick();
        check("t2_error",     64'(ifc.load_error),   64'd1);
        check("t2_cpu_reset", 64'(ifc.cpu_reset),    64'd1);
        check("t2_rx_ready",  64'(ifc.rx_ready),     64'd0);
        check("t2_we_cnt",    64'(we_cnt - we0),     64'd2);
        check("t2_mem1",      64'(dut_mem[1]),       64'h21090005);

        // over-length program rejected right after LEN_LO
        pulse_reload();
        we0 = we_cnt;
        send(8'h04, 0, 1'b0);
        send(8'h01, 0, 1'b0);
        check("t3_error",  64'(ifc.load_error), 64'd1);
        tick();
        check("t3_we_cnt", 64'(we_cnt - we0),   64'd0);

        // empty program
        pulse_reload();
        we0 = we_cnt;
        send(8'h00, 0, 1'b0);
        send(8'h00, 0, 1'b0);
        send(8'h00, 0, 1'b0);
        tick();
        check("t4_done",   64'(ifc.load_done),    64'd1);
        check("t4_words",  64'(ifc.words_loaded), 64'd0);
        check("t4_we_cnt", 64'(we_cnt - we0),     64'd0);

        // rx_valid toggling every cycle
        pulse_reload();
        we0 = we_cnt;
        send_stream(s1_good, 1, 1'b0);
        check("t5_done",   64'(ifc.load_done), 64'd1);
        check("t5_we_cnt", 64'(we_cnt - we0),  64'd2);
        check("t5_mem0",   64'(dut_mem[0]),    64'h3C080010);

        // reset mid-word, then full reload of the same program
        pulse_reload();
        for (int i = 0; i < 8; i++) send(s1_good[i], 0, 1'b0);
        do_reset();
        check("t6_rst_done", 64'(ifc.load_done), 64'd0);
        send_stream(s1_good, 0, 1'b0);
        tick();
        check("t6_done", 64'(ifc.load_done), 64'd1);
        check("t6_mem0", 64'(dut_mem[0]),    64'h3C080010);
        pulse_reload();
        check("t6_reload_cpu_reset", 64'(ifc.cpu_reset), 64'd1);
        check("t6_reload_rx_ready",  64'(ifc.rx_ready),  64'd1);
        make_stream(3, 1'b0, rs);
        send_stream(rs, 0, 1'b0);
        tick();
        check("t6_second_done", 64'(ifc.load_done), 64'd1);

        // randomized programs with gaps, bad checksums and ignored reload pulses
        for (int r = 0; r < 16; r++) begin
            pulse_reload();
            n   = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 12);
            bad = ($urandom_range(0, 3) == 0);
            make_stream(n, bad, rs);
            send_stream(rs, 2, 1'b1);
            tick();
            check("rand_done",  64'(ifc.load_done),  64'(!bad));
            check("rand_error", 64'(ifc.load_error), 64'(bad));
        end

        // largest legal program fills every address
        pulse_reload();
        make_stream(MAX_WORDS, 1'b0, rs);
        send_stream(rs, 0, 1'b0);
        tick();
        check("max_done",  64'(ifc.load_done),    64'd1);
        check("max_words", 64'(ifc.words_loaded), 64'(MAX_WORDS));
        check("max_last",  64'(dut_mem[MAX_WORDS-1]),
              64'({rs[4*MAX_WORDS-2], rs[4*MAX_WORDS-1], rs[4*MAX_WORDS], rs[4*MAX_WORDS+1]}));
        check("max_addr",  64'(ifc.im_addr),      64'(MAX_WORDS - 1));

        // 0xFFFF length rejected
        pulse_reload();
        send(8'hFF, 0, 1'b0);
        send(8'hFF, 0, 1'b0);
        check("ffff_error", 64'(ifc.load_error), 64'd1);
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end
endmodule
